regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port successor to the CPU's 32x32 register file.
- Two write ports with fixed priority, and two combinational read ports with optional write-to-read bypass.
- Register 0 is hardwired to zero.
- Integrated per-register busy scoreboard, used by the pipelined core for RAW hazard detection.
- Sits between decode (reads, busy lookup, busy set) and writeback (both write ports).

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; register count NREG = 2**ADDR_W.
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes and is never busy; 0 = register 0 is ordinary storage.
- BYPASS, 1: 1 = read ports return same-cycle write data; 0 = reads return stored value only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- we0  in  1  write enable, port 0 (low priority).
- waddr0  in  ADDR_W  write address, port 0.
- wdata0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (high priority).
- waddr1  in  ADDR_W  write address, port 1.
- wdata1  in  DATA_W  write data, port 1.
- raddr1  in  ADDR_W  read address A.
- rdata1  out  DATA_W  read data A, combinational.
- raddr2  in  ADDR_W  read address B.
- rdata2  out  DATA_W  read data B, combinational.
- bset  in  1  mark register busy (instruction issued with destination).
- baddr  in  ADDR_W  register to mark busy.
- busy1  out  1  busy bit of raddr1, combinational.
- busy2  out  1  busy bit of raddr2, combinational.
- busy_any  out  1  OR of all busy bits, registered view of state.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset:
  - rst high at a rising edge clears all NREG registers to 0 and all busy bits to 0.
  - rst overrides we0, we1 and bset in that cycle.
  - After reset: rdata1 = rdata2 = 0, busy1 = busy2 = busy_any = 0.
  - rst asserted in the middle of a write/busy sequence discards all pending state. No partial update is allowed.
- Writes:
  - On a rising edge, if weN is high (and, when ZERO_REG=1, waddrN != 0), reg[waddrN] <= wdataN.
  - Both ports enabled, different addresses: both registers are written.
  - Both ports enabled, same address: the port 1 value is stored.
- Reads:
  - rdataK = reg[raddrK] combinationally.
  - ZERO_REG=1 and raddrK = 0: rdataK = 0 regardless of writes.
  - BYPASS=1: if we1 and waddr1 == raddrK (non-zero under ZERO_REG), rdataK = wdata1. Otherwise, if we0 and waddr0 == raddrK, rdataK = wdata0. Otherwise the stored value is returned.
  - Bypass gives write-then-read in one cycle without a falling-edge write.
- Scoreboard:
  - Writing a register through either port clears its busy bit at the edge.
  - bset sets busy[baddr] at the edge.
  - bset and a write to the same address in the same cycle: the set wins, and the bit ends up 1 (a new producer supersedes the completing one).
  - ZERO_REG=1: baddr = 0 is ignored.
  - busyK = busy[raddrK], with no bypass of same-cycle set/clear (decode stalls one extra cycle; accepted).
  - busy_any is the registered OR of the busy vector after the edge's updates.
- Widths: all addresses are used as-is; out-of-range cannot occur because NREG = 2**ADDR_W.

Test Plan:
- Reset then read: rst for 2 cycles; raddr1=5, raddr2=31 -> rdata1=rdata2=0, busy1=busy2=busy_any=0.
- Basic write/read:
  - Drive we0=1, waddr0=3, wdata0=32'hDEADBEEF for one edge, then we0=0 and raddr1=3 -> rdata1=32'hDEADBEEF.
  - With we0=1 active in the same cycle and raddr2=3, BYPASS=1 -> rdata2 shows the new value before the edge.
- Write conflict: we0=we1=1, waddr0=waddr1=7, wdata0=32'h1, wdata1=32'h2 -> after the edge reg7 reads 32'h2. Same test with different addresses (7 and 8) -> reg7=1, reg8=2.
- Zero register:
  - we1=1, waddr1=0, wdata1=32'hFFFFFFFF, then raddr1=0 -> rdata1=0.
  - bset with baddr=0 -> busy1=0 and busy_any=0.
- Scoreboard:
  - bset, baddr=9 -> next cycle busy for raddr1=9 is 1 and busy_any=1.
  - Then we0 write to 9 -> busy clears and busy_any=0.
  - bset baddr=9 together with we1 write to 9 -> busy stays 1 and reg9 holds the new data.
- Reset mid-operation: busy set on 4 and reg4=32'hA5A5A5A5, then rst in the same cycle as we0 writing 32'h1234 to 4 -> reg4=0, busy 4=0, busy_any=0.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with RAW busy scoreboard.
// Two write ports (port 1 has priority on address collision) are written at
// the rising edge. Two read ports are combinational with optional
// write-to-read bypass. Per-register busy bits are set by decode (bset) and
// cleared by writeback. With ZERO_REG=1, register 0 always reads 0, ignores
// writes and is never busy.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   we0/waddr0/wdata0         write port 0 (low priority)
//   we1/waddr1/wdata1         write port 1 (high priority)
//   raddr1/rdata1             read port A (combinational)
//   raddr2/rdata2             read port B (combinational)
//   bset/baddr                mark register busy
//   busy1/busy2               busy bit of raddr1/raddr2 (combinational, no bypass)
//   busy_any                  registered OR of all busy bits
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              bset,
  input  logic [ADDR_W-1:0] baddr,
  output logic              busy1,
  output logic              busy2,
  output logic              busy_any
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic              busy_any_q;
  logic              busy_any_d;

  logic wr0_ok;
  logic wr1_ok;
  logic bset_ok;

  // Register 0 is excluded from writes and busy marking when hardwired.
  always_comb begin
    wr0_ok  = we0;
    wr1_ok  = we1;
    bset_ok = bset;
    if (ZERO_REG != 0) begin
      wr0_ok  = we0  && (waddr0 != '0);
      wr1_ok  = we1  && (waddr1 != '0);
      bset_ok = bset && (baddr  != '0);
    end
  end

  // Next state: port 0 then port 1 so port 1 wins a collision; busy set last so
  // a new producer overrides a completing write to the same register.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr0_ok) begin
      regs_d[waddr0] = wdata0;
      busy_d[waddr0] = 1'b0;
    end
    if (wr1_ok) begin
      regs_d[waddr1] = wdata1;
      busy_d[waddr1] = 1'b0;
    end
    if (bset_ok) begin
      busy_d[baddr] = 1'b1;
    end
    busy_any_d = |busy_d;
  end

  // State registers; reset overrides all same-cycle writes and busy sets.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_any_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_any_q <= busy_any_d;
    end
  end

  // Read port A with optional bypass (port 1 data takes precedence).
  always_comb begin
    rdata1 = regs_q[raddr1];
    if (BYPASS != 0) begin
      if (wr0_ok && (waddr0 == raddr1)) rdata1 = wdata0;
      if (wr1_ok && (waddr1 == raddr1)) rdata1 = wdata1;
    end
    if ((ZERO_REG != 0) && (raddr1 == '0)) rdata1 = '0;
  end

  // Read port B with optional bypass (port 1 data takes precedence).
  always_comb begin
    rdata2 = regs_q[raddr2];
    if (BYPASS != 0) begin
      if (wr0_ok && (waddr0 == raddr2)) rdata2 = wdata0;
      if (wr1_ok && (waddr2_hit_1())) rdata2 = wdata1;
    end
    if ((ZERO_REG != 0) && (raddr2 == '0)) rdata2 = '0;
  end

  function automatic logic waddr2_hit_1();
    return waddr1 == raddr2;
  endfunction

  // Busy lookup reflects stored state only; same-cycle set/clear is not bypassed.
  always_comb begin
    busy1 = busy_q[raddr1];
    busy2 = busy_q[raddr2];
  end

  assign busy_any = busy_any_q;

endmodule
